axi_arbiter_n: RTL
==================

AXI_ARBITER_N -- requirements
Module: axi_arbiter_n

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_RD, 2, number of read masters (2..8).
- RR_EN, 1, 1 = round-robin read arbitration; 0 = fixed priority, lowest index wins.
- WR_BLOCKS_RD, 1, 1 = no new read grant while a write is in flight.
- WR_ID, 4'd0, ID driven on awid and wid.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low. Ports are named aclk and aresetn.
REQ-003 Ports, one per line: name, direction, width, meaning.
- aclk, in, 1, clock.
- aresetn, in, 1, synchronous active-low reset.
- m_araddr, in, NUM_RD*32, packed read addresses; master i owns bits [32i+31:32i].
- m_arlen, in, NUM_RD*4, packed burst length minus 1.
- m_arvalid, in, NUM_RD, per-master read-address valid.
- m_arready, out, NUM_RD, per-master read-address ready.
- m_rdata, out, 32, read data broadcast to all masters.
- m_rlast, out, 1, last-beat flag broadcast to all masters.
- m_rvalid, out, NUM_RD, read-data valid to the granted master only.
- m_rready, in, NUM_RD, per-master read-data ready.
- w_awaddr, in, 32, write-master address.
- w_awlen, in, 4, write-master burst length minus 1.
- w_awsize, in, 3, write-master beat size.
- w_awvalid, in, 1, write-address valid.
- w_awready, out, 1, write-address ready.
- w_wdata, in, 32, write data.
- w_wstrb, in, 4, write byte strobes.
- w_wlast, in, 1, last write beat.
- w_wvalid, in, 1, write-data valid.
- w_wready, out, 1, write-data ready.
- w_bvalid, out, 1, write-response valid.
- w_bready, in, 1, write-response ready.
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid, out, 4/32/8/3/2/2/4/3/1, outer AXI AR channel.
- arready, in, 1, outer AR ready.
- rid/rdata/rresp/rlast/rvalid, in, 4/32/2/1/1, outer AXI R channel.
- rready, out, 1, outer R ready.
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid, out, 4/32/8/3/2/2/4/3/1, outer AXI AW channel.
- awready, in, 1, outer AW ready.
- wid/wdata/wstrb/wlast/wvalid, out, 4/32/4/1/1, outer AXI W channel.
- wready, in, 1, outer W ready.
- bid/bresp/bvalid, in, 4/2/1, outer AXI B channel.
- bready, out, 1, outer B ready.

Function
REQ-004 Read FSM states SHALL be R_IDLE, R_ADDR and R_DATA. One read burst is outstanding at a time.
REQ-005 In R_IDLE, when any m_arvalid bit is set (and the write-blocking gate is open), the FSM SHALL register a grant index and move to R_ADDR. Outer arvalid asserts the cycle after the request is seen (1-cycle latency).
REQ-006 Fixed priority: the lowest set index wins. Round-robin: the first set index at or after rr_ptr, wrapping modulo NUM_RD, wins. rr_ptr becomes grant+1 (mod NUM_RD) when the burst completes.
REQ-007 R_ADDR outputs:
- arvalid = m_arvalid[grant]; araddr = the granted address; arlen = {4'b0, m_arlen[grant]}; arid = grant.
- arsize = 3'b010, arburst = 2'b01, arlock = arcache = arprot = 0.
- m_arready[grant] = arready; all other m_arready bits = 0.
- Move to R_DATA on arvalid&&arready. The grant is held until then, even if the granted master drops arvalid.
REQ-008 R_DATA outputs:
- m_rvalid[grant] = rvalid; other m_rvalid bits = 0.
- rready = m_rready[grant].
- m_rdata = rdata and m_rlast = rlast, unregistered.
- Return to R_IDLE on rvalid&&rready&&rlast. A new grant is possible in the cycle after that (no back-to-back grant in the same cycle).
REQ-009 rid and rresp SHALL be ignored. In R_IDLE and R_ADDR: rready = 0 and all m_rvalid bits = 0.
REQ-010 Write FSM states SHALL be W_IDLE, W_ADDR, W_DATA and W_RESP.
- W_IDLE to W_ADDR on w_awvalid.
- W_ADDR: awvalid = 1, AW fields passed through, awid = WR_ID, awburst = 2'b01, awlen = {4'b0, w_awlen}. w_awready = awready. Move to W_DATA on awvalid&&awready.
- W_DATA: wvalid = w_wvalid, w_wready = wready, wid = WR_ID. Move to W_RESP on wvalid&&wready&&wlast.
- W_RESP: w_bvalid = bvalid, bready = w_bready. Move to W_IDLE on bvalid&&bready.
REQ-011 With WR_BLOCKS_RD=1, R_IDLE SHALL NOT grant while the write FSM is not in W_IDLE, or is leaving W_IDLE this cycle; a simultaneous read and write request therefore goes to the write. A read already granted is unaffected by a later write. With WR_BLOCKS_RD=0, the two FSMs are fully independent.
REQ-012 Outer valid/ready outputs not listed for a given state SHALL be 0.

Reset
REQ-013 While aresetn=0 at a rising edge, the block SHALL set: both FSMs to IDLE, rr_ptr = 0, grant = 0.
REQ-014 During reset, all valid/ready outputs (arvalid, rready, awvalid, wvalid, bready, m_arready, m_rvalid, w_awready, w_wready, w_bvalid) SHALL be 0. Reset asserted mid-burst abandons the burst with no completion signalled.

Verification
REQ-015 NUM_RD=2, RR_EN=1, both arvalid set with addr0=0x1000 and addr1=0x2000, arlen=3 -> first burst arid=0, araddr=0x1000; second burst arid=1, araddr=0x2000, each with 4 beats; rr_ptr=0 afterward.
REQ-016 RR_EN=0, master1 requesting, master0 raises arvalid during master1's R_DATA -> master1's burst completes, then master0 is granted; master0 always wins ties.
REQ-017 WR_BLOCKS_RD=1, w_awvalid and m_arvalid[0] set in the same cycle, awlen=0 -> AW handshake, then W, then B; outer arvalid stays 0 until the cycle after the B handshake.
REQ-018 Outer rvalid toggling with rready held low by the granted master -> no beat is lost; rlast is accepted only on the final handshake; m_rvalid of the other master stays 0 throughout.
REQ-019 aresetn pulled low in R_DATA after beat 2 of 4 -> the next cycle shows all valid/ready outputs at 0 and the FSM in R_IDLE; a new request after reset is granted to master 0.

Source files
------------

// File: rtl/axi_arbiter_n.sv
// -----------------------------------------------------------------------------
// axi_arbiter_n
//
// Purpose
//   Shares one outer AXI port between NUM_RD simple read masters and a single
//   write master. Reads are serialised: one read burst is outstanding at a
//   time, and the burst owner is picked by round-robin or fixed priority. The
//   write path is a four-state sequencer that walks AW, W and B in order. With
//   WR_BLOCKS_RD set, a pending or active write holds off new read grants.
//
// Handshake rule (every channel, both sides)
//   A beat transfers on a rising aclk edge where valid and ready are both 1.
//   A valid driven by this block is never gated by its own ready. A read
//   grant is held until its AR handshake, even if that master drops arvalid.
//
// Ports
//   aclk, aresetn          : clock, synchronous active-low reset
//   m_ar*, m_r*            : NUM_RD read masters, packed per master
//                            (master i owns addr bits [32i+31:32i], len [4i+3:4i])
//   w_aw*, w_w*, w_b*      : the single write master
//   ar*, r*, aw*, w*, b*   : outer AXI master port
//   dbg_rd_state_o         : read FSM state (0 R_IDLE, 1 R_ADDR, 2 R_DATA)
//   dbg_wr_state_o         : write FSM state (0 W_IDLE, 1 W_ADDR, 2 W_DATA, 3 W_RESP)
//   dbg_grant_o            : registered read grant index
//   dbg_rr_ptr_o           : round-robin search start index
// -----------------------------------------------------------------------------
module axi_arbiter_n #(
   parameter int          NUM_RD       = 2,
   parameter int          RR_EN        = 1,
   parameter int          WR_BLOCKS_RD = 1,
   parameter logic [3:0]  WR_ID        = 4'd0,
   localparam int         GW           = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
   input  logic                   aclk,
   input  logic                   aresetn,

   // read masters
   input  logic [NUM_RD*32-1:0]   m_araddr,
   input  logic [NUM_RD*4-1:0]    m_arlen,
   input  logic [NUM_RD-1:0]      m_arvalid,
   output logic [NUM_RD-1:0]      m_arready,
   output logic [31:0]            m_rdata,
   output logic                   m_rlast,
   output logic [NUM_RD-1:0]      m_rvalid,
   input  logic [NUM_RD-1:0]      m_rready,

   // write master
   input  logic [31:0]            w_awaddr,
   input  logic [3:0]             w_awlen,
   input  logic [2:0]             w_awsize,
   input  logic                   w_awvalid,
   output logic                   w_awready,
   input  logic [31:0]            w_wdata,
   input  logic [3:0]             w_wstrb,
   input  logic                   w_wlast,
   input  logic                   w_wvalid,
   output logic                   w_wready,
   output logic                   w_bvalid,
   input  logic                   w_bready,

   // outer AR channel
   output logic [3:0]             arid,
   output logic [31:0]            araddr,
   output logic [7:0]             arlen,
   output logic [2:0]             arsize,
   output logic [1:0]             arburst,
   output logic [1:0]             arlock,
   output logic [3:0]             arcache,
   output logic [2:0]             arprot,
   output logic                   arvalid,
   input  logic                   arready,

   // outer R channel
   input  logic [3:0]             rid,
   input  logic [31:0]            rdata,
   input  logic [1:0]             rresp,
   input  logic                   rlast,
   input  logic                   rvalid,
   output logic                   rready,

   // outer AW channel
   output logic [3:0]             awid,
   output logic [31:0]            awaddr,
   output logic [7:0]             awlen,
   output logic [2:0]             awsize,
   output logic [1:0]             awburst,
   output logic [1:0]             awlock,
   output logic [3:0]             awcache,
   output logic [2:0]             awprot,
   output logic                   awvalid,
   input  logic                   awready,

   // outer W channel
   output logic [3:0]             wid,
   output logic [31:0]            wdata,
   output logic [3:0]             wstrb,
   output logic                   wlast,
   output logic                   wvalid,
   input  logic                   wready,

   // outer B channel
   input  logic [3:0]             bid,
   input  logic [1:0]             bresp,
   input  logic                   bvalid,
   output logic                   bready,

   // debug visibility
   output logic [1:0]             dbg_rd_state_o,
   output logic [1:0]             dbg_wr_state_o,
   output logic [GW-1:0]          dbg_grant_o,
   output logic [GW-1:0]          dbg_rr_ptr_o
);

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ADDR = 2'd1,
      W_DATA = 2'd2,
      W_RESP = 2'd3
   } wr_state_e;

   rd_state_e        rd_state_q, rd_state_d;
   wr_state_e        wr_state_q, wr_state_d;
   logic [GW-1:0]    grant_q, grant_d;
   logic [GW-1:0]    rr_ptr_q, rr_ptr_d;

   // Per-master views of the packed request buses.
   logic [31:0]      addr_arr [NUM_RD];
   logic [3:0]       len_arr  [NUM_RD];

   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         addr_arr[i] = m_araddr[i*32 +: 32];
         len_arr[i]  = m_arlen[i*4 +: 4];
      end
   end

   // ---------------------------------------------------------------------------
   // Grant selection. The loop runs from the far end of the search order back
   // to its start so the last hit (smallest offset) is the winner.
   // Fixed priority searches from index 0; round-robin searches from rr_ptr.
   // ---------------------------------------------------------------------------
   logic [GW-1:0]    pick_idx;
   logic [GW-1:0]    cand_idx;
   int               cand;

   always_comb begin
      pick_idx = '0;
      cand_idx = '0;
      cand     = 0;
      for (int k = NUM_RD - 1; k >= 0; k--) begin
         if (RR_EN != 0) begin
            cand = (int'(rr_ptr_q) + k) % NUM_RD;
         end else begin
            cand = k;
         end
         cand_idx = GW'(cand);
         if (m_arvalid[cand_idx]) begin
            pick_idx = cand_idx;
         end
      end
   end

   // A write that is active, or is leaving W_IDLE this very cycle, closes the
   // read gate so a simultaneous read and write request resolves to the write.
   logic wr_busy;
   logic rd_gate_open;

   assign wr_busy      = (wr_state_q != W_IDLE) || w_awvalid;
   assign rd_gate_open = (WR_BLOCKS_RD == 0) || !wr_busy;

   // ---------------------------------------------------------------------------
   // Read FSM: next state and channel steering.
   // ---------------------------------------------------------------------------
   logic ar_fire;
   logic r_last_fire;

   assign ar_fire     = m_arvalid[grant_q] && arready;
   assign r_last_fire = rvalid && m_rready[grant_q] && rlast;

   always_comb begin
      rd_state_d = rd_state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      arvalid    = 1'b0;
      m_arready  = '0;
      rready     = 1'b0;
      m_rvalid   = '0;

      case (rd_state_q)
         R_IDLE: begin
            if ((|m_arvalid) && rd_gate_open) begin
               grant_d    = pick_idx;
               rd_state_d = R_ADDR;
            end
         end
         R_ADDR: begin
            arvalid            = m_arvalid[grant_q];
            m_arready[grant_q] = arready;
            if (ar_fire) begin
               rd_state_d = R_DATA;
            end
         end
         R_DATA: begin
            m_rvalid[grant_q] = rvalid;
            rready            = m_rready[grant_q];
            if (r_last_fire) begin
               rd_state_d = R_IDLE;
               rr_ptr_d   = (grant_q == GW'(NUM_RD - 1)) ? '0 : grant_q + 1'b1;
            end
         end
         default: begin
            rd_state_d = R_IDLE;
         end
      endcase

      // Handshake outputs are silenced for the whole reset window, not only
      // after the first reset edge has cleared the state registers.
      if (!aresetn) begin
         arvalid   = 1'b0;
         m_arready = '0;
         rready    = 1'b0;
         m_rvalid  = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Write FSM: AW, then W until wlast, then B.
   // ---------------------------------------------------------------------------
   always_comb begin
      wr_state_d = wr_state_q;
      awvalid    = 1'b0;
      w_awready  = 1'b0;
      wvalid     = 1'b0;
      w_wready   = 1'b0;
      w_bvalid   = 1'b0;
      bready     = 1'b0;

      case (wr_state_q)
         W_IDLE: begin
            if (w_awvalid) begin
               wr_state_d = W_ADDR;
            end
         end
         W_ADDR: begin
            awvalid   = 1'b1;
            w_awready = awready;
            if (awready) begin
               wr_state_d = W_DATA;
            end
         end
         W_DATA: begin
            wvalid   = w_wvalid;
            w_wready = wready;
            if (w_wvalid && wready && w_wlast) begin
               wr_state_d = W_RESP;
            end
         end
         W_RESP: begin
            w_bvalid = bvalid;
            bready   = w_bready;
            if (bvalid && w_bready) begin
               wr_state_d = W_IDLE;
            end
         end
         default: begin
            wr_state_d = W_IDLE;
         end
      endcase

      if (!aresetn) begin
         awvalid   = 1'b0;
         w_awready = 1'b0;
         wvalid    = 1'b0;
         w_wready  = 1'b0;
         w_bvalid  = 1'b0;
         bready    = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         rd_state_q <= R_IDLE;
         wr_state_q <= W_IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         wr_state_q <= wr_state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Payload fields. These follow the grant / write master unconditionally;
   // only the valid/ready pairs are state dependent.
   // ---------------------------------------------------------------------------
   assign arid    = 4'(grant_q);
   assign araddr  = addr_arr[grant_q];
   assign arlen   = {4'b0000, len_arr[grant_q]};
   assign arsize  = 3'b010;
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'b0000;
   assign arprot  = 3'b000;

   // Read data and last are broadcast; only m_rvalid selects the owner.
   assign m_rdata = rdata;
   assign m_rlast = rlast;

   assign awid    = WR_ID;
   assign awaddr  = w_awaddr;
   assign awlen   = {4'b0000, w_awlen};
   assign awsize  = w_awsize;
   assign awburst = 2'b01;
   assign awlock  = 2'b00;
   assign awcache = 4'b0000;
   assign awprot  = 3'b000;

   assign wid     = WR_ID;
   assign wdata   = w_wdata;
   assign wstrb   = w_wstrb;
   assign wlast   = w_wlast;

   // Response IDs and codes are not forwarded: one burst per direction is
   // outstanding, so the ID carries no routing information.
   logic unused_resp;
   assign unused_resp = ^{rid, rresp, bid, bresp};

   assign dbg_rd_state_o = rd_state_q;
   assign dbg_wr_state_o = wr_state_q;
   assign dbg_grant_o    = grant_q;
   assign dbg_rr_ptr_o   = rr_ptr_q;

endmodule
